// File: rtl/fifo_8.sv
// ---------------------------------------------------------------------------
// fifo_8
//   Synchronous FIFO buffering one output lane of the 1x2 packet demux.
//   The write side takes the demux push/data pair directly. The read side
//   presents registered data with a one-cycle valid strobe. Occupancy flags
//   feed back-pressure and flow-control logic.
//
//   Optional feature: define FIFO_8_ERROR_EN to add the sticky fifo_error_o
//   flag. It sets on any overflow or underflow attempt and clears only on
//   reset.
//
// Ports
//   clk_i            single clock; all state updates on the rising edge
//   reset_i          synchronous active-high reset
//   push_i           write request (demux push_N)
//   data_in_i        write data (demux outN)
//   pop_i            read request
//   data_out_o       registered read data; holds its value when no pop occurs
//   valid_out_o      one-cycle strobe marking a newly popped word
//   count_o          occupancy, 0..DEPTH
//   full_o           count == DEPTH
//   empty_o          count == 0
//   almost_full_o    count >= ALMOST_FULL_TH
//   almost_empty_o   count <= ALMOST_EMPTY_TH
//   fifo_error_o     sticky overflow/underflow flag (FIFO_8_ERROR_EN only)
// ---------------------------------------------------------------------------
module fifo_8 #(
    parameter int DATA_WIDTH      = 8,
    parameter int ADDR_WIDTH      = 2,
    parameter int ALMOST_FULL_TH  = 3,
    parameter int ALMOST_EMPTY_TH = 1
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] data_in_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] data_out_o,
    output logic                  valid_out_o,
    output logic [ADDR_WIDTH:0]   count_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  almost_full_o,
`ifdef FIFO_8_ERROR_EN
    output logic                  almost_empty_o,
    output logic                  fifo_error_o
`else
    output logic                  almost_empty_o
`endif
);

    localparam int                DEPTH   = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_TH_C = (ADDR_WIDTH+1)'(ALMOST_FULL_TH);
    localparam logic [ADDR_WIDTH:0] AE_TH_C = (ADDR_WIDTH+1)'(ALMOST_EMPTY_TH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  valid_out_q, valid_out_d;

    logic full, empty;
    logic push_ok, pop_ok;

    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);

    // A full FIFO still accepts a push when a pop frees a slot in the same
    // cycle. An empty FIFO never forwards the incoming word straight to the
    // output: the pop is rejected and the push lands in memory.
    assign push_ok = push_i && (!full || pop_i);
    assign pop_ok  = pop_i && !empty;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        data_out_d  = data_out_q;
        valid_out_d = 1'b0;

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
        end
        if (pop_ok) begin
            rd_ptr_d    = rd_ptr_q + ADDR_WIDTH'(1);
            data_out_d  = mem_q[rd_ptr_q];
            valid_out_d = 1'b1;
        end

        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + (ADDR_WIDTH+1)'(1);
            2'b01:   count_d = count_q - (ADDR_WIDTH+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            data_out_q  <= '0;
            valid_out_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
        end
    end

    // Storage is not reset. Stale words are unreachable once the pointers
    // and count clear.
    always_ff @(posedge clk_i) begin
        if (!reset_i && push_ok) begin
            mem_q[wr_ptr_q] <= data_in_i;
        end
    end

`ifdef FIFO_8_ERROR_EN
    logic fifo_error_q, fifo_error_d;

    always_comb begin
        fifo_error_d = fifo_error_q;
        if ((push_i && full && !pop_i) || (pop_i && empty)) begin
            fifo_error_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            fifo_error_q <= 1'b0;
        end else begin
            fifo_error_q <= fifo_error_d;
        end
    end

    assign fifo_error_o = fifo_error_q;
`endif

    assign data_out_o     = data_out_q;
    assign valid_out_o    = valid_out_q;
    assign count_o        = count_q;
    assign full_o         = full;
    assign empty_o        = empty;
    assign almost_full_o  = (count_q >= AF_TH_C);
    assign almost_empty_o = (count_q <= AE_TH_C);

endmodule

// File: doc/fifo_8.md
# fifo_8

Synchronous 8-bit FIFO that buffers one output lane of the 1x2 packet demux in the adaptive PCIe switching datapath. It takes the demux's `push_N`/`outN` pair directly as its write side. It presents registered read data with a valid strobe to the downstream arbiter/pop logic. Occupancy thresholds drive back-pressure and flow-control decisions.

## Interface
- `DATA_WIDTH`, 8, word width
- `ADDR_WIDTH`, 2, address width; depth = 2**ADDR_WIDTH (4)
- `ALMOST_FULL_TH`, 3, `almost_full` asserts when count >= this value
- `ALMOST_EMPTY_TH`, 1, `almost_empty` asserts when count <= this value
- `clk`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `push`  in  1  write request; connects to the demux `push_0`/`push_1`
- `data_in`  in  DATA_WIDTH  write data; connects to the demux `out0`/`out1`
- `pop`  in  1  read request
- `data_out`  out  DATA_WIDTH  registered read data
- `valid_out`  out  1  high for one cycle when `data_out` carries a newly popped word
- `count`  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
- `full`  out  1  count == DEPTH
- `empty`  out  1  count == 0
- `almost_full`  out  1  count >= ALMOST_FULL_TH
- `almost_empty`  out  1  count <= ALMOST_EMPTY_TH
- `fifo_error`  out  1  sticky overflow/underflow flag (present only with the macro; see Configuration)

## Operation
- Storage: DEPTH x DATA_WIDTH register array, write pointer `wr_ptr`, read pointer `rd_ptr`, each ADDR_WIDTH bits.
  - Both pointers wrap naturally modulo DEPTH.
  - `count` is a separate ADDR_WIDTH+1 register, so full and empty are distinguishable.
- Push is accepted when `push && (!full || pop)`. On acceptance:
  - `mem[wr_ptr] <= data_in`
  - `wr_ptr` increments.
- Pop is accepted when `pop && !empty`. On acceptance:
  - `data_out <= mem[rd_ptr]`
  - `rd_ptr` increments
  - `valid_out <= 1`.
- When no pop is accepted, `valid_out <= 0` and `data_out` holds its value.
- Count update per cycle:
  - push only: +1
  - pop only: −1
  - both or neither: unchanged.
- Simultaneous push and pop:
  - Full: both accepted; count stays DEPTH.
  - Empty: pop rejected, push accepted; count becomes 1. No write-through bypass.
  - Otherwise: both accepted.
- Overflow (push while full, no pop): the word is dropped and pointers are unchanged.
- Underflow (pop while empty): ignored; `valid_out` stays 0.
- Flags (`full`, `empty`, `almost_full`, `almost_empty`) are combinational decodes of registered `count`.

## Timing
- Reset (`reset == 1` at rising edge) clears:
  - `wr_ptr = rd_ptr = count = 0`
  - `data_out = 0`, `valid_out = 0`, `fifo_error = 0`.
- Memory contents are not cleared.
- Reset has priority over push and pop in the same cycle. A mid-operation reset discards all stored words.
- Reset values after reset: `empty=1`, `almost_empty=1`, `full=0`, `almost_full=0`.
- Write-to-visible latency: data pushed at edge N is poppable at edge N+1. It appears on `data_out` with `valid_out=1` after the edge where the pop is accepted.
- Pop-to-data latency: 1 cycle (registered output).
- Flags reflect the post-edge count. Upstream must sample `full` before driving `push`; the demux has no stall input, so a lost word is an overflow.

## Configuration
- `FIFO_8_ERROR_EN` defined:
  - The `fifo_error` port exists.
  - It sets to 1 on any overflow or underflow attempt and holds until `reset`.
- `FIFO_8_ERROR_EN` undefined:
  - The port and logic are removed.
  - Overflow and underflow are silently ignored, with identical data-path behaviour.

## Test plan
- Reset, then push 0xA1, 0xB2, 0xC3, 0xD4 on consecutive cycles:
  - `count` goes 1, 2, 3, 4.
  - `almost_full` rises when count=3; `full=1` at count=4.
  - `empty=0` from count=1.
- From full, pop 4 times:
  - `data_out` = 0xA1, 0xB2, 0xC3, 0xD4, each with a one-cycle `valid_out`.
  - End state `empty=1`, `count=0`.
- Full FIFO, push 0xEE with no pop:
  - Count stays 4 and the word is dropped.
  - `fifo_error=1` (macro on).
  - Draining yields only the original 4 words.
- Full FIFO, push 0x55 with pop in the same cycle:
  - `data_out`=oldest word, count stays 4.
  - 0x55 is the last word drained.
- Empty FIFO, push 0x77 with pop in the same cycle:
  - `valid_out=0`, count=1.
  - The next pop returns 0x77.
- Wrap check: 10 interleaved push/pop pairs on incrementing data 0x00..0x09 return in order. Then assert `reset` with count=2: next edge gives count=0, `empty=1`, `valid_out=0`, `fifo_error=0`.
